// File: rtl/frame_check.sv
// -----------------------------------------------------------------------------
// frame_check
//   Checks a repeating 4-word training frame arriving from a 16-bit GTP receive
//   path. It hunts for the K28.5 comma pair in either byte alignment, verifies
//   LOCK_FRAMES consecutive good frames before declaring lock, and then reports
//   every frame as good or bad. Lock is dropped after UNLOCK_ERRS consecutive
//   bad frames.
//
//   Frame (aligned words, byte [7:0] first on the wire):
//     word 0 16'hBCBC k=11, word 1 16'h5854, word 2 16'h4034, word 3 16'h23A7
//
// Ports
//   aclk       receive recovered clock, all logic on rising edge
//   aresetn    asynchronous active-low reset
//   rx_data    16-bit receive word, byte [7:0] received first
//   rx_is_k    per-byte K flag for rx_data
//   ready      receiver reset done; words ignored while low
//   clr        synchronous clear of frame_cnt / err_cnt (wins over increment)
//   locked     high in the LOCKED state
//   odd_align  selected byte alignment is odd
//   frame_ok   one-cycle pulse per good frame (LOCKED only)
//   frame_err  one-cycle pulse per bad frame (LOCKED only)
//   frame_cnt  saturating count of good frames
//   err_cnt    saturating count of bad frames
// -----------------------------------------------------------------------------
module frame_check #(
  parameter int LOCK_FRAMES = 4,
  parameter int UNLOCK_ERRS = 4,
  parameter int CNT_W       = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [15:0]      rx_data,
  input  logic [1:0]       rx_is_k,
  input  logic             ready,
  input  logic             clr,
  output logic             locked,
  output logic             odd_align,
  output logic             frame_ok,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int RUN_MAX = (LOCK_FRAMES > UNLOCK_ERRS) ? LOCK_FRAMES : UNLOCK_ERRS;
  localparam int RUN_W   = (RUN_MAX > 1) ? $clog2(RUN_MAX + 1) : 1;
  localparam logic [RUN_W-1:0] LOCK_LAST   = RUN_W'(LOCK_FRAMES - 1);
  localparam logic [RUN_W-1:0] UNLOCK_LAST = RUN_W'(UNLOCK_ERRS - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Stage 1: build both byte alignments and register them.
  // Only the upper byte of the previous word is ever needed (odd alignment).
  // ---------------------------------------------------------------------------
  logic [7:0]  r_prev_hi;
  logic        r_prev_k_hi;
  logic        r_prev_valid;
  logic [15:0] r_even_data;
  logic [1:0]  r_even_k;
  logic [15:0] r_odd_data;
  logic [1:0]  r_odd_k;
  logic        r_al_valid;
  logic        r_odd_valid;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_prev_hi    <= '0;
      r_prev_k_hi  <= 1'b0;
      r_prev_valid <= 1'b0;
      r_even_data  <= '0;
      r_even_k     <= '0;
      r_odd_data   <= '0;
      r_odd_k      <= '0;
      r_al_valid   <= 1'b0;
      r_odd_valid  <= 1'b0;
    end else if (!ready) begin
      // Receiver not ready: the previous word no longer forms a valid pair.
      r_prev_valid <= 1'b0;
      r_al_valid   <= 1'b0;
      r_odd_valid  <= 1'b0;
    end else begin
      r_prev_hi    <= rx_data[15:8];
      r_prev_k_hi  <= rx_is_k[1];
      r_prev_valid <= 1'b1;
      r_even_data  <= rx_data;
      r_even_k     <= rx_is_k;
      r_odd_data   <= {rx_data[7:0], r_prev_hi};
      r_odd_k      <= {rx_is_k[0], r_prev_k_hi};
      r_al_valid   <= 1'b1;
      r_odd_valid  <= r_prev_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: frame FSM
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [1:0]       r_idx;
  logic             r_odd_align;
  logic             r_bad_acc;
  logic             r_hunt_frame;
  logic [RUN_W-1:0] r_good_run;
  logic [RUN_W-1:0] r_err_run;
  logic             r_frame_ok;
  logic             r_frame_err;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  state_t           w_state_next;
  logic [1:0]       w_idx_next;
  logic             w_odd_align_next;
  logic             w_bad_acc_next;
  logic             w_hunt_frame_next;
  logic [RUN_W-1:0] w_good_run_next;
  logic [RUN_W-1:0] w_err_run_next;
  logic             w_frame_ok_next;
  logic             w_frame_err_next;

  logic [15:0] w_exp_data;
  logic [1:0]  w_exp_k;
  logic [15:0] w_sel_data;
  logic [1:0]  w_sel_k;
  logic        w_even_comma;
  logic        w_odd_comma;
  logic        w_mismatch;
  logic        w_frame_bad;

  always_comb begin
    w_exp_data = 16'h23A7;
    w_exp_k    = 2'b00;
    case (r_idx)
      2'd0: begin w_exp_data = 16'hBCBC; w_exp_k = 2'b11; end
      2'd1: begin w_exp_data = 16'h5854; w_exp_k = 2'b00; end
      2'd2: begin w_exp_data = 16'h4034; w_exp_k = 2'b00; end
      default: begin w_exp_data = 16'h23A7; w_exp_k = 2'b00; end
    endcase
  end

  assign w_even_comma = r_al_valid  && (r_even_data == 16'hBCBC) && (r_even_k == 2'b11);
  assign w_odd_comma  = r_odd_valid && (r_odd_data  == 16'hBCBC) && (r_odd_k  == 2'b11);
  assign w_sel_data   = r_odd_align ? r_odd_data : r_even_data;
  assign w_sel_k      = r_odd_align ? r_odd_k    : r_even_k;
  // Any comma outside index 0 simply fails this compare; the index is never
  // resynchronised while verifying or locked.
  assign w_mismatch   = (w_sel_data != w_exp_data) || (w_sel_k != w_exp_k);
  assign w_frame_bad  = r_bad_acc | w_mismatch;

  always_comb begin
    w_state_next      = r_state;
    w_idx_next        = r_idx;
    w_odd_align_next  = r_odd_align;
    w_bad_acc_next    = r_bad_acc;
    w_hunt_frame_next = r_hunt_frame;
    w_good_run_next   = r_good_run;
    w_err_run_next    = r_err_run;
    w_frame_ok_next   = 1'b0;
    w_frame_err_next  = 1'b0;

    if (!ready) begin
      w_state_next      = HUNT;
      w_idx_next        = 2'd0;
      w_odd_align_next  = 1'b0;
      w_bad_acc_next    = 1'b0;
      w_hunt_frame_next = 1'b0;
      w_good_run_next   = '0;
      w_err_run_next    = '0;
    end else if (r_al_valid) begin
      case (r_state)
        HUNT: begin
          if (w_even_comma || w_odd_comma) begin
            w_odd_align_next  = !w_even_comma;  // even wins a tie
            w_idx_next        = 2'd1;
            w_state_next      = VERIFY;
            w_good_run_next   = '0;
            w_bad_acc_next    = 1'b0;
            w_hunt_frame_next = 1'b1;
          end
        end

        VERIFY: begin
          w_idx_next     = r_idx + 2'd1;
          w_bad_acc_next = w_frame_bad;
          if (r_idx == 2'd3) begin
            w_bad_acc_next = 1'b0;
            if (w_frame_bad) begin
              w_state_next = HUNT;
              w_idx_next   = 2'd0;
            end else if (r_hunt_frame) begin
              // The frame whose comma was found while hunting does not
              // count towards the lock run.
              w_hunt_frame_next = 1'b0;
            end else if (r_good_run == LOCK_LAST) begin
              w_state_next   = LOCKED;
              w_err_run_next = '0;
            end else begin
              w_good_run_next = r_good_run + 1'b1;
            end
          end
        end

        LOCKED: begin
          w_idx_next     = r_idx + 2'd1;
          w_bad_acc_next = w_frame_bad;
          if (r_idx == 2'd3) begin
            w_bad_acc_next = 1'b0;
            if (w_frame_bad) begin
              w_frame_err_next = 1'b1;
              if (r_err_run == UNLOCK_LAST) begin
                w_state_next = HUNT;
                w_idx_next   = 2'd0;
              end else begin
                w_err_run_next = r_err_run + 1'b1;
              end
            end else begin
              w_frame_ok_next = 1'b1;
              w_err_run_next  = '0;
            end
          end
        end

        default: begin
          w_state_next = HUNT;
          w_idx_next   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= HUNT;
      r_idx        <= 2'd0;
      r_odd_align  <= 1'b0;
      r_bad_acc    <= 1'b0;
      r_hunt_frame <= 1'b0;
      r_good_run   <= '0;
      r_err_run    <= '0;
      r_frame_ok   <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_idx        <= w_idx_next;
      r_odd_align  <= w_odd_align_next;
      r_bad_acc    <= w_bad_acc_next;
      r_hunt_frame <= w_hunt_frame_next;
      r_good_run   <= w_good_run_next;
      r_err_run    <= w_err_run_next;
      r_frame_ok   <= w_frame_ok_next;
      r_frame_err  <= w_frame_err_next;
    end
  end

  // Counters follow the registered pulses, so a clr in the pulse cycle meets
  // the increment on the same edge and wins. ready low stops new pulses,
  // which holds the counters.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else if (clr) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (r_frame_ok && (r_frame_cnt != {CNT_W{1'b1}}))
        r_frame_cnt <= r_frame_cnt + 1'b1;
      if (r_frame_err && (r_err_cnt != {CNT_W{1'b1}}))
        r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign locked    = (r_state == LOCKED);
  assign odd_align = r_odd_align;
  assign frame_ok  = r_frame_ok;
  assign frame_err = r_frame_err;
  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_frame_check.sv
// -----------------------------------------------------------------------------
// tb_frame_check
//   Directed bench for frame_check (CNT_W = 4). Frames are pushed as bytes;
//   the last byte of each frame carries the pulse it must produce (none, ok,
//   err). When the word carrying that byte is driven, the expected pulse and
//   its cycle (drive cycle + 2) go into a scoreboard queue; a monitor on the
//   falling edge pops and compares every pulse the DUT emits.
// -----------------------------------------------------------------------------
module tb_frame_check;

  localparam int CNT_W = 4;
  localparam int T_NONE = 0;
  localparam int T_OK   = 1;
  localparam int T_ERR  = 2;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic [15:0]      rx_data = '0;
  logic [1:0]       rx_is_k = '0;
  logic             ready = 1'b0;
  logic             clr = 1'b0;
  logic             locked;
  logic             odd_align;
  logic             frame_ok;
  logic             frame_err;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] err_cnt;

  frame_check #(
    .LOCK_FRAMES(4),
    .UNLOCK_ERRS(4),
    .CNT_W(CNT_W)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .rx_data(rx_data),
    .rx_is_k(rx_is_k),
    .ready(ready),
    .clr(clr),
    .locked(locked),
    .odd_align(odd_align),
    .frame_ok(frame_ok),
    .frame_err(frame_err),
    .frame_cnt(frame_cnt),
    .err_cnt(err_cnt)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int kind;
    int at;
  } exp_t;
  exp_t sb_q[$];

  logic [7:0] bq_d[$];
  logic       bq_k[$];
  int         bq_t[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_byte(input logic [7:0] d, input logic k, input int tag);
    bq_d.push_back(d);
    bq_k.push_back(k);
    bq_t.push_back(tag);
  endtask

  task automatic push_frame(input bit corrupt, input int tag);
    push_byte(8'hBC, 1'b1, T_NONE);
    push_byte(8'hBC, 1'b1, T_NONE);
    push_byte(8'h54, 1'b0, T_NONE);
    push_byte(8'h58, 1'b0, T_NONE);
    push_byte(corrupt ? 8'h35 : 8'h34, 1'b0, T_NONE);
    push_byte(8'h40, 1'b0, T_NONE);
    push_byte(8'hA7, 1'b0, T_NONE);
    push_byte(8'h23, 1'b0, tag);
  endtask

  task automatic clear_bytes();
    bq_d.delete();
    bq_k.delete();
    bq_t.delete();
  endtask

  task automatic note_tag(input int tag);
    exp_t e;
    if (tag != T_NONE) begin
      e.kind = tag;
      e.at   = cyc + 2;
      sb_q.push_back(e);
    end
  endtask

  task automatic drive_word(input logic c);
    logic [7:0] lo, hi;
    logic       klo, khi;
    int         tlo, thi;
    while (bq_d.size() < 2) push_byte(8'h00, 1'b0, T_NONE);
    @(posedge aclk);
    #1;
    lo  = bq_d.pop_front();  klo = bq_k.pop_front();  tlo = bq_t.pop_front();
    hi  = bq_d.pop_front();  khi = bq_k.pop_front();  thi = bq_t.pop_front();
    ready   = 1'b1;
    clr     = c;
    rx_data = {hi, lo};
    rx_is_k = {khi, klo};
    note_tag(tlo);
    note_tag(thi);
  endtask

  task automatic drain();
    while (bq_d.size() >= 2) drive_word(1'b0);
  endtask

  task automatic send_frame(input bit corrupt, input int tag, input int clr_w);
    push_frame(corrupt, tag);
    for (int w = 0; bq_d.size() >= 2; w++) drive_word(w == clr_w);
  endtask

  task automatic send_partial(input int nwords);
    push_frame(1'b0, T_NONE);
    repeat (nwords) drive_word(1'b0);
    clear_bytes();
  endtask

  task automatic ready_low(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
      ready   = 1'b0;
      clr     = 1'b0;
      rx_data = '0;
      rx_is_k = '0;
    end
  endtask

  // Scoreboard monitor
  always @(negedge aclk) begin
    int   kind;
    exp_t e;
    if (frame_ok || frame_err) begin
      kind = frame_ok ? T_OK : T_ERR;
      check("pulse_exclusive", int'(frame_ok && frame_err), 0);
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, required no pulse", kind, cyc);
      end else begin
        e = sb_q.pop_front();
        n_checks++;
        if (e.kind != kind || e.at != cyc) begin
          n_fail++;
          $display("FAIL pulse: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                   kind, cyc, e.kind, e.at);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check("rst_locked", int'(locked), 0);
    check("rst_odd", int'(odd_align), 0);
    check("rst_ok", int'(frame_ok), 0);
    check("rst_err", int'(frame_err), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);
    check("rst_err_cnt", int'(err_cnt), 0);
    aresetn = 1'b1;
    ready   = 1'b1;
    drain();
    push_byte(8'h00, 1'b0, T_NONE); push_byte(8'h00, 1'b0, T_NONE);
    push_byte(8'h00, 1'b0, T_NONE); push_byte(8'h00, 1'b0, T_NONE);
    drain();

    // Even lock: hunt frame + 4 good frames
    repeat (4) send_frame(1'b0, T_NONE, -1);
    send_frame(1'b0, T_NONE, -1);                  // F5
    check("even_not_yet_locked", int'(locked), 0);
    send_frame(1'b0, T_OK, -1);                    // F6
    check("even_locked", int'(locked), 1);
    check("even_odd_align", int'(odd_align), 0);
    check("even_cnt_f6", int'(frame_cnt), 0);
    send_frame(1'b0, T_OK, -1);                    // F7
    send_frame(1'b0, T_OK, -1);                    // F8

    // Single corruption
    send_frame(1'b1, T_ERR, -1);                   // F9
    check("even_cnt_f9", int'(frame_cnt), 3);
    check("even_errcnt_f9", int'(err_cnt), 0);
    send_frame(1'b0, T_OK, -1);                    // F10
    check("single_err_cnt", int'(err_cnt), 1);
    check("single_err_locked", int'(locked), 1);
    send_frame(1'b0, T_OK, -1);                    // F11
    check("single_frame_cnt", int'(frame_cnt), 4);

    // Loss of lock: 4 bad frames
    repeat (3) send_frame(1'b1, T_ERR, -1);        // F12..F14
    send_frame(1'b1, T_ERR, -1);                   // F15
    check("unlock_err_cnt_3", int'(err_cnt), 4);
    check("unlock_still_locked", int'(locked), 1);
    send_frame(1'b0, T_NONE, -1);                  // F16 hunt frame
    check("unlock_locked", int'(locked), 0);
    check("unlock_err_cnt", int'(err_cnt), 5);
    check("unlock_frame_cnt", int'(frame_cnt), 5);
    repeat (4) send_frame(1'b0, T_NONE, -1);       // F17..F20
    send_frame(1'b0, T_OK, -1);                    // F21
    check("relock_locked", int'(locked), 1);
    send_frame(1'b0, T_OK, -1);                    // F22
    check("relock_frame_cnt", int'(frame_cnt), 6);

    // Clear, then saturation with 20 good frames
    send_frame(1'b0, T_OK, 2);                     // F23, clr mid-frame
    send_frame(1'b0, T_OK, -1);                    // F24
    check("clr_frame_cnt", int'(frame_cnt), 1);
    check("clr_err_cnt", int'(err_cnt), 0);
    repeat (18) send_frame(1'b0, T_OK, -1);        // F25..F42
    send_frame(1'b0, T_OK, -1);                    // F43
    check("sat_frame_cnt", int'(frame_cnt), 15);
    // clr on the cycle F43's frame_ok is high
    send_frame(1'b0, T_OK, 1);                     // F44
    check("clr_priority_cnt", int'(frame_cnt), 0);

    // ready low for 3 cycles mid-frame
    send_frame(1'b0, T_OK, -1);                    // F45
    send_partial(2);
    ready_low(3);
    check("rdy_locked", int'(locked), 0);
    check("rdy_odd", int'(odd_align), 0);
    check("rdy_ok", int'(frame_ok), 0);
    check("rdy_err", int'(frame_err), 0);
    check("rdy_frame_cnt_held", int'(frame_cnt), 2);
    check("rdy_err_cnt_held", int'(err_cnt), 0);
    repeat (5) send_frame(1'b0, T_NONE, -1);       // F47..F51
    send_frame(1'b0, T_OK, -1);                    // F52
    check("rdy_relock", int'(locked), 1);
    send_frame(1'b0, T_OK, -1);                    // F53

    // Asynchronous reset mid-frame
    send_partial(3);
    #2;
    aresetn = 1'b0;
    #1;
    check("arst_locked", int'(locked), 0);
    check("arst_ok", int'(frame_ok), 0);
    check("arst_err", int'(frame_err), 0);
    check("arst_frame_cnt", int'(frame_cnt), 0);
    check("arst_err_cnt", int'(err_cnt), 0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;

    // Odd alignment: stream delayed by one byte
    push_byte(8'h00, 1'b0, T_NONE);
    repeat (5) send_frame(1'b0, T_NONE, -1);       // F55..F59
    send_frame(1'b0, T_OK, -1);                    // F60
    check("odd_locked", int'(locked), 1);
    check("odd_align", int'(odd_align), 1);
    send_frame(1'b0, T_OK, -1);                    // F61
    send_frame(1'b0, T_OK, -1);                    // F62
    push_byte(8'h00, 1'b0, T_NONE);
    drain();                                       // word carrying F62's last byte
    repeat (4) push_byte(8'h00, 1'b0, T_NONE);
    drain();
    ready_low(4);
    check("odd_frame_cnt", int'(frame_cnt), 3);
    check("odd_err_cnt", int'(err_cnt), 0);

    repeat (4) @(posedge aclk);
    #1;
    check("sb_all_pulses_seen", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_check.md
FRAME_CHECK -- requirements
Module: frame_check

Interface
REQ-001 SHALL have parameter LOCK_FRAMES, default 4: consecutive good frames needed to declare lock.
REQ-002 SHALL have parameter UNLOCK_ERRS, default 4: consecutive bad frames that drop lock.
REQ-003 SHALL have parameter CNT_W, default 32: width of the frame and error counters.
REQ-004 SHALL have port aclk, input, 1 bit: the single clock (the SFP receive recovered clock); all logic is on its rising edge.
REQ-005 SHALL have port aresetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port rx_data, input, 16 bits: receive word from the GTP; byte [7:0] is received first.
REQ-007 SHALL have port rx_is_k, input, 2 bits: per-byte K-character flag for rx_data.
REQ-008 SHALL have port ready, input, 1 bit: receiver reset done; while low, input words are ignored.
REQ-009 SHALL have port clr, input, 1 bit: synchronous clear of frame_cnt and err_cnt.
REQ-010 SHALL have port locked, output, 1 bit: high in the LOCKED state.
REQ-011 SHALL have port odd_align, output, 1 bit: the selected byte alignment is odd.
REQ-012 SHALL have port frame_ok, output, 1 bit: one-cycle pulse per good frame.
REQ-013 SHALL have port frame_err, output, 1 bit: one-cycle pulse per bad frame.
REQ-014 SHALL have port frame_cnt, output, CNT_W bits: count of good frames.
REQ-015 SHALL have port err_cnt, output, CNT_W bits: count of bad frames.

Function
REQ-016 A frame SHALL be 4 aligned words in this order, with aligned K flags as given:
- word 0: 16'hBCBC, k = 2'b11 (K28.5 K28.5)
- word 1: 16'h5854, k = 2'b00
- word 2: 16'h4034, k = 2'b00
- word 3: 16'h23A7, k = 2'b00
REQ-017 Even alignment SHALL use aligned word = rx_data and aligned k = rx_is_k, registered once.
REQ-018 Odd alignment SHALL use aligned word = {rx_data[7:0], prev_data[15:8]} and aligned k = {rx_is_k[0], prev_k[1]}, where prev_* is the previous accepted input word.
REQ-019 The comma check SHALL evaluate both alignments every cycle; even alignment SHALL win if both match.
REQ-020 The FSM SHALL have states HUNT, VERIFY and LOCKED; the reset state SHALL be HUNT.
REQ-021 In HUNT, a comma in either alignment SHALL:
- latch odd_align;
- set the word index to 1;
- move the FSM to VERIFY;
- set the good-frame run count to 0.
REQ-022 In VERIFY and LOCKED, the word index SHALL advance modulo 4 on each accepted word, and each aligned word SHALL be compared with the REQ-016 word for its index, data and k together.
REQ-023 A frame SHALL be bad if any of its 4 words mismatches; the verdict SHALL be issued at index 3.
REQ-024 In VERIFY:
- a bad frame SHALL return the FSM to HUNT;
- LOCK_FRAMES consecutive good frames SHALL enter LOCKED;
- no frame_ok/frame_err pulses or counter updates SHALL occur in VERIFY.
REQ-025 In LOCKED:
- each frame SHALL pulse exactly one of frame_ok / frame_err;
- a good frame SHALL clear the bad-frame run count;
- UNLOCK_ERRS consecutive bad frames SHALL return the FSM to HUNT.
REQ-026 Latency: frame_ok/frame_err SHALL pulse 2 aclk cycles after the rx_data word carrying the frame's last byte.
REQ-027 frame_cnt SHALL increment on frame_ok, err_cnt on frame_err; both SHALL saturate at all-ones and never wrap.
REQ-028 clr SHALL zero both counters on the next edge; clr SHALL take priority over a simultaneous increment.
REQ-029 ready low SHALL:
- force HUNT;
- deassert locked;
- suppress pulses;
- invalidate prev_data;
- hold the counters.
REQ-030 A comma appearing at a non-zero index while in LOCKED SHALL count as a mismatch; it SHALL NOT resynchronise the word index.

Reset
REQ-031 aresetn low SHALL immediately force:
- FSM state HUNT;
- locked = 0, odd_align = 0, frame_ok = 0, frame_err = 0;
- frame_cnt = 0, err_cnt = 0;
- word index, run counts and pipeline registers all to 0.
REQ-032 Reset mid-frame SHALL discard the partial frame, with no pulse after release.
REQ-033 After release, the first comma SHALL be hunted afresh.

Verification
REQ-034 Even lock: ready = 1, repeating frame stream with even alignment -> locked = 1 after 1 hunt frame plus 4 good frames; frame_cnt increments by 1 per frame; err_cnt = 0.
REQ-035 Odd alignment: same stream delayed by one byte -> odd_align = 1; locked = 1; frame_cnt counting; err_cnt = 0.
REQ-036 Single corruption: while locked, word 2 = 16'h4035 for one frame -> exactly one frame_err pulse; err_cnt = 1; locked stays 1.
REQ-037 Loss of lock: 4 consecutive corrupted frames -> err_cnt += 4, then locked = 0 and FSM in HUNT; clean stream then relocks.
REQ-038 Saturation and clear: with CNT_W = 4, feed 20 good frames -> frame_cnt = 4'hF; clr asserted in the same cycle as a frame_ok -> frame_cnt = 0.
REQ-039 Reset and ready: aresetn low mid-frame, or ready low for 3 cycles -> all outputs at reset values (counters held for ready); no spurious pulse; relock within 5 frames.
